riscv_lsu: RTL and testbench
============================

// Module: riscv_lsu
// PURPOSE
//  Load-store unit: executes the memory request the main decoder emits (mem_req/mem_we/mem_size)
//  against the data-memory bus. Builds byte enables and replicated write data, stalls the core
//  until the bus responds, and sign/zero-extends load data. Flags misaligned and timed-out accesses.
// PARAMETERS
//  TIMEOUT_CYCLES  16  max cycles in REQ without mem_ready_i before access fault; 0 = never time out
// PORTS
//  clk_i               in   1   clock, all state on rising edge
//  rst_i               in   1   synchronous, active-high reset
//  core_req_i          in   1   access request; held by core while core_stall_o=1
//  core_we_i           in   1   1=store, 0=load
//  core_size_i         in   3   B=0 H=1 W=2 BU=4 HU=5 (3,6,7 illegal)
//  core_addr_i         in   32  byte address
//  core_wd_i           in   32  store data (low bits significant)
//  core_rd_o           out  32  extended load data, valid in DONE
//  core_stall_o        out  1   core must hold pipeline
//  lsu_misaligned_o    out  1   1-cycle pulse in DONE: misaligned access
//  lsu_access_fault_o  out  1   1-cycle pulse in DONE: illegal size or timeout
//  mem_req_o           out  1   bus request
//  mem_we_o            out  1   bus write enable
//  mem_be_o            out  4   byte enables
//  mem_addr_o          out  32  {core_addr_i[31:2],2'b00}
//  mem_wd_o            out  32  replicated store data
//  mem_rd_i            in   32  bus read word, valid with mem_ready_i
//  mem_ready_i         in   1   bus completes current request this cycle
// BEHAVIOUR
//  Reset: state=IDLE, timeout counter=0, rdata/size/offset regs=0; all outputs 0.
//  FSM IDLE/REQ/DONE. core_stall_o = core_req_i & (state!=DONE).
//  IDLE: core_req_i & legal & aligned -> mem_req_o=1 same cycle; ready this cycle -> DONE, else REQ.
//        core_req_i & misaligned -> DONE, misaligned flag; illegal size -> DONE, fault flag; no mem_req_o.
//  REQ: mem_req_o=1, bus outputs follow core inputs (core holds them stable). mem_ready_i -> DONE;
//       counter reaches TIMEOUT_CYCLES-1 without ready -> DONE, fault flag, mem_req_o drops.
//  DONE: mem_req_o=0, stall=0, flags pulse, core_rd_o valid; next cycle -> IDLE unconditionally.
//  Min load/store latency 2 cycles (1 stall cycle); ready in DONE/IDLE with mem_req_o=0 is ignored.
//  Misaligned: H/HU with addr[0]=1; W with addr[1:0]!=0. B/BU never misaligned.
//  mem_be_o: B/BU 4'b0001<<addr[1:0]; H/HU 4'b0011<<{addr[1],1'b0}; W 4'b1111; 0 when mem_req_o=0.
//  mem_wd_o: B {4{wd[7:0]}}; H {2{wd[15:0]}}; W wd. Stores with BU/HU treated as B/H.
//  Load capture: on mem_ready_i in IDLE/REQ with !we, register mem_rd_i, size, addr[1:0].
//  core_rd_o: B/BU select byte at offset, sign/zero extend to 32; H/HU halfword at addr[1]; W raw.
//  core_rd_o=0 on stores, faults and outside DONE.
//  Timeout counter clears on leaving REQ; saturating, width $clog2(TIMEOUT_CYCLES+1).
//  core_req_i dropped in REQ (protocol violation): abandon, back to IDLE, no flags.
//  rst_i mid-transaction: next edge IDLE, mem_req_o=0, pending response discarded.
// TESTING
//  LW addr 0x104, ready 1 cycle later, mem_rd=0xDEADBEEF -> be=1111, addr 0x104, stall 2 cycles, rd=0xDEADBEEF.
//  LB addr 0x103 rd 0x80xxxxxx -> rd=0xFFFFFF80; LBU same -> 0x00000080; LHU addr 0x102 rd 0xBEEFxxxx -> 0x0000BEEF.
//  SB addr 0x101 wd 0x12345678 -> be=0010, wd=0x78787878; SH addr 0x102 -> be=1100, wd=0x56785678.
//  LW addr 0x102 -> no mem_req_o, 1 stall cycle, misaligned pulse; size=3 -> access fault pulse.
//  TIMEOUT_CYCLES=4, ready never -> mem_req_o high 4 cycles then fault pulse, stall released.
//  rst_i in REQ then ready -> IDLE, outputs 0, late ready ignored, next LW completes normally.

Source files
------------

// File: rtl/riscv_lsu_if.sv
// Data-memory bus between the load-store unit (master) and the memory system (slave).
interface riscv_lsu_if;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wd_o;
    logic [31:0] mem_rd_i;
    logic        mem_ready_i;

    modport master (
        output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o,
        input  mem_rd_i, mem_ready_i
    );

    modport slave (
        input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o,
        output mem_rd_i, mem_ready_i
    );
endinterface

// File: rtl/riscv_lsu.sv
// Load-store unit: drives one data-memory access per core request, stalls the core until
// the bus answers, and returns the extended load word plus misaligned/fault pulses.
module riscv_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         core_req_i,
    input  logic         core_we_i,
    input  logic [2:0]   core_size_i,
    input  logic [31:0]  core_addr_i,
    input  logic [31:0]  core_wd_i,
    output logic [31:0]  core_rd_o,
    output logic         core_stall_o,
    output logic         lsu_misaligned_o,
    output logic         lsu_access_fault_o,
    riscv_lsu_if.master  bus
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
    localparam logic TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [2:0]       size_q, size_d;
    logic [1:0]       off_q, off_d;
    logic             loadOk_q, loadOk_d;
    logic             mis_q, mis_d;
    logic             fault_q, fault_d;

    logic             isLegal, isMisaligned, issue, memReq;
    logic [CNT_W-1:0] cntInc;
    logic [7:0]       selByte;
    logic [15:0]      selHalf;
    logic [31:0]      extData;

    always_comb begin
        isLegal = (core_size_i == 3'd0) || (core_size_i == 3'd1) || (core_size_i == 3'd2) ||
                  (core_size_i == 3'd4) || (core_size_i == 3'd5);
        isMisaligned = ((core_size_i[1:0] == 2'd1) && core_addr_i[0]) ||
                       ((core_size_i[1:0] == 2'd2) && (core_addr_i[1:0] != 2'b00));
        issue  = ((state_q == IDLE) && core_req_i && isLegal && !isMisaligned) ||
                 ((state_q == REQ) && core_req_i);
        memReq = issue && !rst_i;
        cntInc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    end

    // Counter tracks how many cycles mem_req_o has been high for the current access,
    // so a timeout of N means exactly N request cycles before the fault.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        size_d   = size_q;
        off_d    = off_q;
        loadOk_d = 1'b0;
        mis_d    = 1'b0;
        fault_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (core_req_i) begin
                    if (!isLegal) begin
                        fault_d = 1'b1;
                        state_d = DONE;
                    end else if (isMisaligned) begin
                        mis_d   = 1'b1;
                        state_d = DONE;
                    end else if (bus.mem_ready_i) begin
                        state_d = DONE;
                    end else begin
                        state_d = REQ;
                        cnt_d   = cntInc;
                    end
                end
            end
            REQ: begin
                if (!core_req_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (bus.mem_ready_i) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else if (TIMEOUT_EN && (cnt_q >= CNT_LAST)) begin
                    state_d = DONE;
                    fault_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cntInc;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (issue && bus.mem_ready_i && !core_we_i) begin
            rdata_d  = bus.mem_rd_i;
            size_d   = core_size_i;
            off_d    = core_addr_i[1:0];
            loadOk_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rdata_q  <= '0;
            size_q   <= '0;
            off_q    <= '0;
            loadOk_q <= 1'b0;
            mis_q    <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            size_q   <= size_d;
            off_q    <= off_d;
            loadOk_q <= loadOk_d;
            mis_q    <= mis_d;
            fault_q  <= fault_d;
        end
    end

    always_comb begin
        selByte = 8'(rdata_q >> {off_q, 3'b000});
        selHalf = off_q[1] ? rdata_q[31:16] : rdata_q[15:0];
        case (size_q[1:0])
            2'd0:    extData = {{24{selByte[7] & ~size_q[2]}}, selByte};
            2'd1:    extData = {{16{selHalf[15] & ~size_q[2]}}, selHalf};
            default: extData = rdata_q;
        endcase
    end

    // Bus outputs are forced low whenever no request is on the bus, keeping it quiet.
    always_comb begin
        bus.mem_req_o  = memReq;
        bus.mem_we_o   = memReq && core_we_i;
        bus.mem_addr_o = memReq ? {core_addr_i[31:2], 2'b00} : 32'd0;
        bus.mem_be_o   = 4'b0000;
        bus.mem_wd_o   = 32'd0;
        if (memReq) begin
            case (core_size_i[1:0])
                2'd0: begin
                    bus.mem_be_o = 4'b0001 << core_addr_i[1:0];
                    bus.mem_wd_o = {4{core_wd_i[7:0]}};
                end
                2'd1: begin
                    bus.mem_be_o = 4'b0011 << {core_addr_i[1], 1'b0};
                    bus.mem_wd_o = {2{core_wd_i[15:0]}};
                end
                default: begin
                    bus.mem_be_o = 4'b1111;
                    bus.mem_wd_o = core_wd_i;
                end
            endcase
        end
        core_stall_o       = core_req_i && (state_q != DONE) && !rst_i;
        core_rd_o          = ((state_q == DONE) && loadOk_q) ? extData : 32'd0;
        lsu_misaligned_o   = (state_q == DONE) && mis_q;
        lsu_access_fault_o = (state_q == DONE) && fault_q;
    end

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed bench for riscv_lsu: loads with extension, stores, misalignment, illegal size,
// timeout, dropped request and mid-access reset, all against hand-computed values.
module tb_riscv_lsu;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        core_req_i;
    logic        core_we_i;
    logic [2:0]  core_size_i;
    logic [31:0] core_addr_i;
    logic [31:0] core_wd_i;
    logic [31:0] core_rd_o;
    logic        core_stall_o;
    logic        lsu_misaligned_o;
    logic        lsu_access_fault_o;

    int checks = 0;
    int failures = 0;

    riscv_lsu_if bus ();

    riscv_lsu #(.TIMEOUT_CYCLES(4)) dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .core_req_i         (core_req_i),
        .core_we_i          (core_we_i),
        .core_size_i        (core_size_i),
        .core_addr_i        (core_addr_i),
        .core_wd_i          (core_wd_i),
        .core_rd_o          (core_rd_o),
        .core_stall_o       (core_stall_o),
        .lsu_misaligned_o   (lsu_misaligned_o),
        .lsu_access_fault_o (lsu_access_fault_o),
        .bus                (bus.master)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic req, input logic we, input logic [2:0] size,
                                 input logic [31:0] addr, input logic [31:0] wd);
        core_req_i  = req;
        core_we_i   = we;
        core_size_i = size;
        core_addr_i = addr;
        core_wd_i   = wd;
        #1;
    endtask

    // Load with the bus answering one cycle after the request; result checked in DONE.
    task automatic runLoad(input string tag, input logic [2:0] size, input logic [31:0] addr,
                           input logic [31:0] memRd, input logic [31:0] expRd);
        applyStimulus(1'b1, 1'b0, size, addr, 32'd0);
        checkOutput({tag, "_req"}, {31'd0, bus.mem_req_o}, 32'd1);
        tick();
        bus.mem_ready_i = 1'b1;
        bus.mem_rd_i    = memRd;
        tick();
        bus.mem_ready_i = 1'b0;
        bus.mem_rd_i    = 32'd0;
        checkOutput({tag, "_rd"}, core_rd_o, expRd);
        checkOutput({tag, "_stall"}, {31'd0, core_stall_o}, 32'd0);
        applyStimulus(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        tick();
    endtask

    initial begin
        bus.mem_rd_i    = 32'd0;
        bus.mem_ready_i = 1'b0;
        rst_i = 1'b1;
        applyStimulus(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        tick();
        tick();
        rst_i = 1'b0;
        #1;
        checkOutput("rst_memreq", {31'd0, bus.mem_req_o}, 32'd0);
        checkOutput("rst_stall", {31'd0, core_stall_o}, 32'd0);
        checkOutput("rst_rd", core_rd_o, 32'd0);
        checkOutput("rst_flags", {30'd0, lsu_misaligned_o, lsu_access_fault_o}, 32'd0);

        $display("[TB] LW 0x104 with one-cycle bus latency");
        applyStimulus(1'b1, 1'b0, 3'd2, 32'h104, 32'd0);
        checkOutput("lw_req", {31'd0, bus.mem_req_o}, 32'd1);
        checkOutput("lw_be", {28'd0, bus.mem_be_o}, 32'hF);
        checkOutput("lw_addr", bus.mem_addr_o, 32'h104);
        checkOutput("lw_stall0", {31'd0, core_stall_o}, 32'd1);
        tick();
        bus.mem_ready_i = 1'b1;
        bus.mem_rd_i    = 32'hDEADBEEF;
        #1;
        checkOutput("lw_stall1", {31'd0, core_stall_o}, 32'd1);
        checkOutput("lw_req1", {31'd0, bus.mem_req_o}, 32'd1);
        tick();
        bus.mem_ready_i = 1'b0;
        checkOutput("lw_rd", core_rd_o, 32'hDEADBEEF);
        checkOutput("lw_stall2", {31'd0, core_stall_o}, 32'd0);
        checkOutput("lw_done_req", {31'd0, bus.mem_req_o}, 32'd0);
        applyStimulus(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        tick();
        checkOutput("lw_idle_rd", core_rd_o, 32'd0);

        runLoad("lb", 3'd0, 32'h103, 32'h80123456, 32'hFFFFFF80);
        runLoad("lbu", 3'd4, 32'h103, 32'h80123456, 32'h00000080);
        runLoad("lhu", 3'd5, 32'h102, 32'hBEEF1234, 32'h0000BEEF);
        runLoad("lh", 3'd1, 32'h102, 32'h80011234, 32'hFFFF8001);
        runLoad("lb0", 3'd0, 32'h100, 32'h000000F0, 32'hFFFFFFF0);

        $display("[TB] stores");
        applyStimulus(1'b1, 1'b1, 3'd0, 32'h101, 32'h12345678);
        checkOutput("sb_be", {28'd0, bus.mem_be_o}, 32'h2);
        checkOutput("sb_wd", bus.mem_wd_o, 32'h78787878);
        checkOutput("sb_addr", bus.mem_addr_o, 32'h100);
        checkOutput("sb_we", {31'd0, bus.mem_we_o}, 32'd1);
        tick();
        bus.mem_ready_i = 1'b1;
        bus.mem_rd_i    = 32'hFFFFFFFF;
        tick();
        bus.mem_ready_i = 1'b0;
        checkOutput("sb_rd", core_rd_o, 32'd0);
        checkOutput("sb_stall", {31'd0, core_stall_o}, 32'd0);
        applyStimulus(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        tick();
        applyStimulus(1'b1, 1'b1, 3'd1, 32'h102, 32'h12345678);
        checkOutput("sh_be", {28'd0, bus.mem_be_o}, 32'hC);
        checkOutput("sh_wd", bus.mem_wd_o, 32'h56785678);
        bus.mem_ready_i = 1'b1;
        tick();
        bus.mem_ready_i = 1'b0;
        checkOutput("sh_fast_stall", {31'd0, core_stall_o}, 32'd0);
        applyStimulus(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        tick();

        $display("[TB] misaligned and illegal size");
        applyStimulus(1'b1, 1'b0, 3'd2, 32'h102, 32'd0);
        checkOutput("mis_req", {31'd0, bus.mem_req_o}, 32'd0);
        checkOutput("mis_stall0", {31'd0, core_stall_o}, 32'd1);
        tick();
        checkOutput("mis_flags", {30'd0, lsu_misaligned_o, lsu_access_fault_o}, 32'h2);
        checkOutput("mis_stall1", {31'd0, core_stall_o}, 32'd0);
        applyStimulus(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        tick();
        checkOutput("mis_pulse_end", {31'd0, lsu_misaligned_o}, 32'd0);
        applyStimulus(1'b1, 1'b0, 3'd3, 32'h100, 32'd0);
        checkOutput("ill_req", {31'd0, bus.mem_req_o}, 32'd0);
        tick();
        checkOutput("ill_flags", {30'd0, lsu_misaligned_o, lsu_access_fault_o}, 32'h1);
        applyStimulus(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        tick();

        $display("[TB] timeout with no bus response");
        applyStimulus(1'b1, 1'b0, 3'd2, 32'h200, 32'd0);
        for (int c = 0; c < 4; c++) begin
            checkOutput($sformatf("to_req%0d", c), {31'd0, bus.mem_req_o}, 32'd1);
            checkOutput($sformatf("to_fault%0d", c), {31'd0, lsu_access_fault_o}, 32'd0);
            tick();
        end
        checkOutput("to_req_drop", {31'd0, bus.mem_req_o}, 32'd0);
        checkOutput("to_fault", {31'd0, lsu_access_fault_o}, 32'd1);
        checkOutput("to_stall", {31'd0, core_stall_o}, 32'd0);
        applyStimulus(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        tick();

        $display("[TB] request dropped mid-access");
        applyStimulus(1'b1, 1'b0, 3'd2, 32'h300, 32'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 3'd2, 32'h300, 32'd0);
        checkOutput("drop_req", {31'd0, bus.mem_req_o}, 32'd0);
        tick();
        checkOutput("drop_flags", {30'd0, lsu_misaligned_o, lsu_access_fault_o}, 32'd0);

        $display("[TB] reset during REQ");
        applyStimulus(1'b1, 1'b0, 3'd2, 32'h400, 32'd0);
        tick();
        rst_i = 1'b1;
        #1;
        checkOutput("rstreq_req", {31'd0, bus.mem_req_o}, 32'd0);
        tick();
        rst_i = 1'b0;
        applyStimulus(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        bus.mem_ready_i = 1'b1;
        bus.mem_rd_i    = 32'hCAFEF00D;
        #1;
        checkOutput("rstreq_idle_req", {31'd0, bus.mem_req_o}, 32'd0);
        tick();
        bus.mem_ready_i = 1'b0;
        checkOutput("late_ready_rd", core_rd_o, 32'd0);
        checkOutput("late_ready_stall", {31'd0, core_stall_o}, 32'd0);
        runLoad("lw_after_rst", 3'd2, 32'h104, 32'h0BADF00D, 32'h0BADF00D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
